// File: rtl/input_debouncer.sv
// input_debouncer
//   Debounces a bank of raw pin inputs (pushbuttons and slide switches) and
//   provides edge pulses plus a sticky rising-edge capture register.
//
//   Each bit passes through these stages:
//     1. Optional inversion (INVERT_MASK), so active-low keys read as active-high.
//     2. A two-flop synchronizer.
//     3. An agreement counter. DB_OUT only toggles after the synchronized input
//        has disagreed with it for STABLE_CYCLES consecutive cycles.
//
// Parameters
//   WIDTH         number of raw inputs (KEY[1:0] in bits 1:0, SW[9:0] in bits 11:2)
//   STABLE_CYCLES consecutive disagreeing cycles before DB_OUT toggles (2..2^CNT_W-1)
//   CNT_W         per-bit counter width
//   INVERT_MASK   1 = invert that raw bit before synchronisation
//
// Ports
//   CLOCK_50  single clock, rising edge
//   RESET_N   asynchronous active-low reset; release must be synchronous
//             (this block does not resynchronise reset)
//   RAW_IN    asynchronous pin inputs
//   CLR       write-one-to-clear strobe for EDGE_CAP
//   DB_OUT    debounced active-high level
//   RISE      one-cycle pulse on a DB_OUT 0->1 transition
//   FALL      one-cycle pulse on a DB_OUT 1->0 transition
//   EDGE_CAP  sticky rising-edge capture; set wins over CLR

module input_debouncer_lane #(
    parameter int STABLE_CYCLES = 1000000,
    parameter int CNT_W         = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pre,
    input  logic clr,
    output logic db,
    output logic rise,
    output logic fall,
    output logic cap
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;
    logic             differ;
    logic             expire;

    assign differ = s2 ^ db;
    // ">=" keeps the counter from ever running past the terminal value,
    // so it can never wrap.
    assign expire = differ && (cnt >= CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            cnt  <= '0;
            db   <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
            cap  <= 1'b0;
        end else begin
            s1 <= pre;
            s2 <= s1;

            // Any agreement restarts the count, so partial counts from a
            // bounce are never retained.
            if (!differ || expire) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end

            if (expire) begin
                db <= s2;
            end

            // The pulses are registered on the same edge that updates db,
            // so each one lines up with the first cycle of the new level.
            rise <= expire & s2;
            fall <= expire & ~s2;

            // A coincident set wins over clear.
            cap  <= (expire & s2) | (cap & ~clr);
        end
    end
endmodule

module input_debouncer #(
    parameter int               WIDTH         = 12,
    parameter int               STABLE_CYCLES = 1000000,
    parameter int               CNT_W         = 20,
    parameter logic [WIDTH-1:0] INVERT_MASK   = 12'h003
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    input  logic [WIDTH-1:0] RAW_IN,
    input  logic [WIDTH-1:0] CLR,
    output logic [WIDTH-1:0] DB_OUT,
    output logic [WIDTH-1:0] RISE,
    output logic [WIDTH-1:0] FALL,
    output logic [WIDTH-1:0] EDGE_CAP
);
    logic [WIDTH-1:0] pre;

    // The inversion sits in front of the synchronizer, so there is no logic
    // between the s1 and s2 flops.
    assign pre = RAW_IN ^ INVERT_MASK;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        input_debouncer_lane #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .CNT_W         (CNT_W)
        ) u_lane (
            .clk   (CLOCK_50),
            .rst_n (RESET_N),
            .pre   (pre[i]),
            .clr   (CLR[i]),
            .db    (DB_OUT[i]),
            .rise  (RISE[i]),
            .fall  (FALL[i]),
            .cap   (EDGE_CAP[i])
        );
    end
endmodule

// File: tb/tb_input_debouncer.sv
module tb_input_debouncer;
    localparam int WIDTH = 12;
    localparam int SC    = 4;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] db;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] cap;

    int checks   = 0;
    int failures = 0;

    input_debouncer #(
        .WIDTH         (WIDTH),
        .STABLE_CYCLES (SC),
        .CNT_W         (20),
        .INVERT_MASK   (12'h003)
    ) dut (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .RAW_IN   (raw),
        .CLR      (clr),
        .DB_OUT   (db),
        .RISE     (rise),
        .FALL     (fall),
        .EDGE_CAP (cap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs set after a step are seen by the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        raw   = 12'h003;
        clr   = '0;
        #1;
        checks++;
        if ({db, rise, fall, cap} !== '0) begin
            failures++;
            $display("FAIL reset_async db=%h rise=%h fall=%h cap=%h want all 0", db, rise, fall, cap);
        end
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            checks++;
            if ({db, rise, fall, cap} !== '0) begin
                failures++;
                $display("FAIL idle_hold cyc=%0d db=%h rise=%h fall=%h cap=%h want all 0", i, db, rise, fall, cap);
            end
        end
    endtask

    task automatic test_rise();
        raw = 12'h003 | 12'h004;
        for (int i = 1; i <= 5; i++) begin
            step();
            checks++;
            if (db[2] !== 1'b0) begin
                failures++;
                $display("FAIL rise_early edge=%0d db2=%b want 0", i, db[2]);
            end
        end
        step();
        checks++;
        if (db !== 12'h004 || rise !== 12'h004 || fall !== 12'h000 || cap !== 12'h004) begin
            failures++;
            $display("FAIL rise_edge6 db=%h rise=%h fall=%h cap=%h want 004 004 000 004", db, rise, fall, cap);
        end
        step();
        checks++;
        if (db !== 12'h004 || rise !== 12'h000 || cap !== 12'h004) begin
            failures++;
            $display("FAIL rise_after db=%h rise=%h cap=%h want 004 000 004", db, rise, cap);
        end
    endtask

    // KEY0 pressed (raw 0) with one-cycle glitches back to released every 3rd cycle.
    task automatic test_bounce();
        for (int i = 0; i < 30; i++) begin
            raw[0] = (i % 3 == 2) ? 1'b1 : 1'b0;
            step();
            checks++;
            if (db[0] !== 1'b0 || rise[0] !== 1'b0) begin
                failures++;
                $display("FAIL bounce_hold cyc=%0d db0=%b rise0=%b want 0 0", i, db[0], rise[0]);
            end
        end
        raw[0] = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step();
            checks++;
            if (db[0] !== 1'b0) begin
                failures++;
                $display("FAIL bounce_early edge=%0d db0=%b want 0", i, db[0]);
            end
        end
        step();
        checks++;
        if (db !== 12'h005 || rise !== 12'h001 || cap !== 12'h005) begin
            failures++;
            $display("FAIL bounce_rise db=%h rise=%h cap=%h want 005 001 005", db, rise, cap);
        end
    endtask

    task automatic test_clr();
        // A plain clear of bit 0 must touch only EDGE_CAP.
        clr = 12'h001;
        step();
        clr = '0;
        checks++;
        if (cap !== 12'h004 || db !== 12'h005 || rise !== 12'h000 || fall !== 12'h000) begin
            failures++;
            $display("FAIL clr_plain cap=%h db=%h rise=%h fall=%h want 004 005 000 000", cap, db, rise, fall);
        end
        // Clear bit 2 on the same edge bit 5 rises.
        raw[5] = 1'b1;
        for (int i = 1; i <= 5; i++) step();
        clr = 12'h004;
        step();
        clr = '0;
        checks++;
        if (cap !== 12'h020 || db !== 12'h025 || rise !== 12'h020) begin
            failures++;
            $display("FAIL clr_other cap=%h db=%h rise=%h want 020 025 020", cap, db, rise);
        end
        // Clear bit 3 on the same edge bit 3 rises: set wins.
        raw[3] = 1'b1;
        for (int i = 1; i <= 5; i++) step();
        clr = 12'h008;
        step();
        clr = '0;
        checks++;
        if (cap !== 12'h028 || db !== 12'h02D) begin
            failures++;
            $display("FAIL clr_same cap=%h db=%h want 028 02d", cap, db);
        end
        step();
        checks++;
        if (cap !== 12'h028) begin
            failures++;
            $display("FAIL clr_same_hold cap=%h want 028", cap);
        end
    endtask

    task automatic test_reset_midcount();
        raw[7] = 1'b1;
        for (int i = 1; i <= 4; i++) step();  // counter for bit 7 now at 2
        rst_n = 1'b0;
        #1;
        checks++;
        if ({db, rise, fall, cap} !== '0) begin
            failures++;
            $display("FAIL mid_reset db=%h rise=%h fall=%h cap=%h want all 0", db, rise, fall, cap);
        end
        step();
        rst_n = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            checks++;
            if (db !== 12'h000 || rise !== 12'h000) begin
                failures++;
                $display("FAIL mid_early edge=%0d db=%h rise=%h want 000 000", i, db, rise);
            end
        end
        // Every held input rises again together, since DB_OUT restarts at 0.
        step();
        checks++;
        if (db !== 12'h0AD || rise !== 12'h0AD || cap !== 12'h0AD || fall !== 12'h000) begin
            failures++;
            $display("FAIL mid_rise db=%h rise=%h cap=%h fall=%h want 0ad 0ad 0ad 000", db, rise, cap, fall);
        end
    endtask

    task automatic test_fall();
        raw[2] = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step();
            checks++;
            if (db[2] !== 1'b1 || fall !== 12'h000) begin
                failures++;
                $display("FAIL fall_early edge=%0d db2=%b fall=%h want 1 000", i, db[2], fall);
            end
        end
        step();
        checks++;
        if (db !== 12'h0A9 || fall !== 12'h004 || rise !== 12'h000 || cap !== 12'h0AD) begin
            failures++;
            $display("FAIL fall_edge6 db=%h fall=%h rise=%h cap=%h want 0a9 004 000 0ad", db, fall, rise, cap);
        end
        step();
        checks++;
        if (fall !== 12'h000 || db !== 12'h0A9) begin
            failures++;
            $display("FAIL fall_after fall=%h db=%h want 000 0a9", fall, db);
        end
    endtask

    initial begin
        test_reset();
        test_rise();
        test_bounce();
        test_clr();
        test_reset_midcount();
        test_fall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/input_debouncer.md
INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 SHALL have parameter WIDTH, default 12, the number of raw inputs (KEY[1:0] in bits 1:0, SW[9:0] in bits 11:2).
REQ-002 SHALL have parameter STABLE_CYCLES, default 1000000, the number of consecutive disagreeing cycles before the output toggles (20 ms at 50 MHz); legal range 2..2^CNT_W-1.
REQ-003 SHALL have parameter CNT_W, default 20, the per-bit counter width.
REQ-004 SHALL have parameter INVERT_MASK, default 12'h003, where a 1 inverts that raw bit before synchronisation (KEY is active-low).
REQ-005 SHALL have port CLOCK_50, input, 1 bit: the single clock; all flops use its rising edge.
REQ-006 SHALL have port RESET_N, input, 1 bit: the asynchronous, active-low reset.
REQ-007 SHALL have port RAW_IN, input, WIDTH bits: asynchronous pin inputs.
REQ-008 SHALL have port CLR, input, WIDTH bits: write-one-to-clear strobe for EDGE_CAP, one cycle per write.
REQ-009 SHALL have port DB_OUT, output, WIDTH bits: the debounced, active-high level, feeding pushbuttons_export and slider_switches_export.
REQ-010 SHALL have port RISE, output, WIDTH bits: a one-cycle pulse on each 0->1 transition of DB_OUT.
REQ-011 SHALL have port FALL, output, WIDTH bits: a one-cycle pulse on each 1->0 transition of DB_OUT.
REQ-012 SHALL have port EDGE_CAP, output, WIDTH bits: a sticky rising-edge capture.

Function
REQ-013 SHALL form pre = RAW_IN ^ INVERT_MASK and pass each bit through a two-flop synchronizer, s1 then s2, with no logic between the flops.
REQ-014 SHALL keep an independent CNT_W-bit counter per bit; bits never interact.
REQ-015 Per bit, when s2 == DB_OUT, the counter SHALL load 0 on the next edge.
REQ-016 Per bit, when s2 != DB_OUT and counter < STABLE_CYCLES-1, the counter SHALL increment by 1; it SHALL never wrap.
REQ-017 Per bit, when s2 != DB_OUT and counter == STABLE_CYCLES-1, DB_OUT SHALL take s2 and the counter SHALL load 0 on the same edge.
REQ-018 Any single-cycle agreement (glitch back) SHALL restart the count from 0, so a partial count is never retained.
REQ-019 Latency SHALL be exactly STABLE_CYCLES+2 rising edges from a stable RAW_IN change to the DB_OUT change.
REQ-020 RISE and FALL SHALL be registered, asserted in exactly the first cycle DB_OUT shows the new value, and deasserted the following cycle.
REQ-021 RISE and FALL SHALL never be asserted together on the same bit.
REQ-022 An EDGE_CAP bit SHALL set on the edge where DB_OUT of that bit goes 0->1.
REQ-023 An EDGE_CAP bit SHALL clear on the edge where its CLR bit is 1.
REQ-024 If set and clear occur on the same edge, set SHALL win.
REQ-025 An EDGE_CAP bit SHALL otherwise hold its value.
REQ-026 CLR SHALL have no effect on DB_OUT, RISE, FALL or the counters.
REQ-027 Input that keeps bouncing with period < STABLE_CYCLES SHALL never change DB_OUT.

Reset
REQ-028 While RESET_N = 0, s1, s2, every counter, DB_OUT, RISE, FALL and EDGE_CAP SHALL be 0, asynchronously and immediately.
REQ-029 A reset asserted mid-count SHALL discard the count.
REQ-030 After reset deassertion, the first RISE SHALL occur no earlier than STABLE_CYCLES+2 edges later.
REQ-031 Leaving reset with RAW_IN already pressed SHALL produce a normal RISE, since DB_OUT starts at 0.
REQ-032 Release of RESET_N SHALL be synchronous to CLOCK_50, handled externally; this block does not resynchronise reset.

Verification (STABLE_CYCLES=4, WIDTH=12, INVERT_MASK=12'h003)
REQ-033 Reset, then RAW_IN=12'h003 held: DB_OUT stays 12'h000, and RISE, FALL and EDGE_CAP stay 0 for 100 cycles.
REQ-034 Drive RAW_IN[2] 0->1 and hold: DB_OUT[2]=1 exactly 6 edges later; RISE[2] high for 1 cycle in that same cycle; EDGE_CAP[2]=1 thereafter.
REQ-035 Drive KEY bit RAW_IN[0] 1->0 with 1-cycle glitches back to 1 every 3 cycles for 30 cycles, then hold 0: DB_OUT[0] unchanged during the bouncing, then rises 6 edges after the final transition.
REQ-036 With EDGE_CAP[2]=1, pulse CLR[2] on the same edge DB_OUT[5] rises: EDGE_CAP[2]=0 and EDGE_CAP[5]=1; CLR pulsed on a coincident set of the same bit leaves EDGE_CAP=1.
REQ-037 Start a 0->1 change on RAW_IN[7]; assert RESET_N=0 at count 2 for 1 cycle; keep RAW_IN[7]=1: DB_OUT[7] rises 6 edges after reset release, not earlier.
REQ-038 Release RAW_IN[2] 1->0: FALL[2] pulses once 6 edges later, DB_OUT[2]=0, and EDGE_CAP[2] is unaffected.
